ikaopll_pg_sequencer: RTL and testbench



---
 rtl/ikaopll_pg_sequencer_pkg.sv | 31 +++
 rtl/ikaopll_pg_sequencer_timinggen.sv | 58 +++++
 rtl/ikaopll_pg_sequencer.sv | 147 ++++++++++++++
 tb/tb_ikaopll_pg_sequencer.sv | 359 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ikaopll_pg_sequencer_pkg.sv
// Shared constants, register layouts and slot helpers for the IKAOPLL sequencers.
package ikaopll_pg_sequencer_pkg;

    localparam int unsigned SLOTS      = 18;
    localparam int unsigned CHANS      = SLOTS / 2;
    localparam int unsigned SLOT_W     = $clog2(SLOTS);
    localparam int unsigned CH_W       = $clog2(CHANS);
    localparam int unsigned PHI1_DIV_W = 2;

    localparam logic [5:0] OP_BASE  = 6'h00;
    localparam logic [5:0] RHY_ADDR = 6'h12;
    localparam logic [5:0] FNL_BASE = 6'h18;
    localparam logic [5:0] FNH_BASE = 6'h28;

    typedef struct packed {
        logic       pm;
        logic [3:0] mul;
    } op_reg_t;

    typedef struct packed {
        logic       keyon;
        logic [2:0] block;
        logic [8:0] fnum;
    } ch_reg_t;

    // Operators are paired modulator/carrier, so the channel is the slot without bit 0.
    function automatic logic [CH_W-1:0] slot_to_ch(input logic [SLOT_W-1:0] slot);
        return slot[SLOT_W-1:1];
    endfunction

endpackage

// File: rtl/ikaopll_pg_sequencer_timinggen.sv
// phiM -> phi1 enable divider, 18-slot operator counter and cycle decodes.
module ikaopll_timinggen #(
    parameter int unsigned SLOTS    = ikaopll_pg_sequencer_pkg::SLOTS,
    parameter int unsigned PHI1_DIV = 4
) (
    input  logic       i_EMUCLK,
    input  logic       i_IC,
    input  logic       i_phiM_PCEN_n,
    output logic       o_phi1_PCEN_n,
    output logic       o_phi1_NCEN_n,
    output logic [4:0] o_SLOT,
    output logic       o_CYCLE_17,
    output logic       o_CYCLE_20,
    output logic       o_CYCLE_21
);
    import ikaopll_pg_sequencer_pkg::*;

    logic [PHI1_DIV_W-1:0] div_q, div_d;
    logic [4:0]            slot_q, slot_d;
    logic                  phim_en, pcen, ncen;

    always_comb begin
        phim_en = ~i_phiM_PCEN_n;
        pcen    = phim_en && (div_q == PHI1_DIV_W'(PHI1_DIV - 1));
        ncen    = phim_en && (div_q == PHI1_DIV_W'(PHI1_DIV / 2 - 1));

        div_d = div_q;
        if (pcen) begin
            div_d = '0;
        end else if (phim_en) begin
            div_d = div_q + 1'b1;
        end

        slot_d = slot_q;
        if (ncen) begin
            slot_d = (slot_q == 5'(SLOTS - 1)) ? '0 : slot_q + 1'b1;
        end
    end

    always_ff @(posedge i_EMUCLK or posedge i_IC) begin
        if (i_IC) begin
            div_q  <= '0;
            slot_q <= '0;
        end else begin
            div_q  <= div_d;
            slot_q <= slot_d;
        end
    end

    // Chip cycle numbers run 18 ahead of the slot index, hence 20/21 on slots 2/3.
    assign o_phi1_PCEN_n = ~pcen;
    assign o_phi1_NCEN_n = ~ncen;
    assign o_SLOT        = slot_q;
    assign o_CYCLE_17    = (slot_q == 5'(SLOTS - 1));
    assign o_CYCLE_20    = (slot_q == 5'd2);
    assign o_CYCLE_21    = (slot_q == 5'd3);

endmodule

// File: rtl/ikaopll_pg_sequencer.sv
// Phase-generator sequencer: PG register file, per-slot parameter mux and key-on phase resets.
module ikaopll_pg_sequencer #(
    parameter int unsigned SLOTS    = ikaopll_pg_sequencer_pkg::SLOTS,
    parameter int unsigned PHI1_DIV = 4
) (
    input  logic       i_EMUCLK,
    input  logic       i_IC,
    input  logic       i_phiM_PCEN_n,
    input  logic       i_WR,
    input  logic [5:0] i_ADDR,
    input  logic [7:0] i_DATA,
    output logic       o_phi1_PCEN_n,
    output logic       o_phi1_NCEN_n,
    output logic [4:0] o_SLOT,
    output logic       o_CYCLE_17,
    output logic       o_CYCLE_20,
    output logic       o_CYCLE_21,
    output logic       o_RHYTHM_EN,
    output logic [8:0] o_FNUM,
    output logic [2:0] o_BLOCK,
    output logic [3:0] o_MUL,
    output logic       o_PM,
    output logic       o_PG_PHASE_RST
);
    import ikaopll_pg_sequencer_pkg::*;

    localparam int unsigned NCH = SLOTS / 2;

    ikaopll_timinggen #(
        .SLOTS    (SLOTS),
        .PHI1_DIV (PHI1_DIV)
    ) u_timinggen (
        .i_EMUCLK      (i_EMUCLK),
        .i_IC          (i_IC),
        .i_phiM_PCEN_n (i_phiM_PCEN_n),
        .o_phi1_PCEN_n (o_phi1_PCEN_n),
        .o_phi1_NCEN_n (o_phi1_NCEN_n),
        .o_SLOT        (o_SLOT),
        .o_CYCLE_17    (o_CYCLE_17),
        .o_CYCLE_20    (o_CYCLE_20),
        .o_CYCLE_21    (o_CYCLE_21)
    );

    op_reg_t           op_q [SLOTS];
    op_reg_t           op_d [SLOTS];
    ch_reg_t           ch_q [NCH];
    ch_reg_t           ch_d [NCH];
    logic              rhy_q, rhy_d;
    logic [SLOTS-1:0]  pend_q, pend_d, pend_set;
    logic [8:0]        fnum_q, fnum_d;
    logic [2:0]        block_q, block_d;
    logic [3:0]        mul_q, mul_d;
    logic              pm_q, pm_d;
    logic              prst_q, prst_d;

    logic [5:0]        op_idx, fnl_idx, fnh_idx;
    logic [CH_W-1:0]   wr_ch;
    logic [SLOT_W-1:0] prev_slot;
    logic [CH_W-1:0]   ch_sel;

    always_comb begin : reg_write
        op_d     = op_q;
        ch_d     = ch_q;
        rhy_d    = rhy_q;
        pend_set = '0;
        op_idx   = i_ADDR - OP_BASE;
        fnl_idx  = i_ADDR - FNL_BASE;
        fnh_idx  = i_ADDR - FNH_BASE;
        wr_ch    = '0;

        if (i_WR) begin
            if (op_idx < 6'(SLOTS)) begin
                op_d[op_idx[SLOT_W-1:0]].pm  = i_DATA[7];
                op_d[op_idx[SLOT_W-1:0]].mul = i_DATA[3:0];
            end else if (i_ADDR == RHY_ADDR) begin
                rhy_d = i_DATA[5];
            end else if (fnl_idx < 6'(NCH)) begin
                ch_d[fnl_idx[CH_W-1:0]].fnum[7:0] = i_DATA;
            end else if (fnh_idx < 6'(NCH)) begin
                wr_ch = fnh_idx[CH_W-1:0];
                // Only a rising key-on restarts the phase of both operators of the channel.
                if (i_DATA[4] && !ch_q[wr_ch].keyon) begin
                    pend_set[{wr_ch, 1'b0}] = 1'b1;
                    pend_set[{wr_ch, 1'b1}] = 1'b1;
                end
                ch_d[wr_ch].keyon   = i_DATA[4];
                ch_d[wr_ch].block   = i_DATA[3:1];
                ch_d[wr_ch].fnum[8] = i_DATA[0];
            end
        end
    end

    always_comb begin : out_load
        prev_slot = (o_SLOT == '0) ? SLOT_W'(SLOTS - 1) : o_SLOT - 1'b1;
        ch_sel    = slot_to_ch(o_SLOT);
        pend_d    = pend_q | pend_set;
        fnum_d    = fnum_q;
        block_d   = block_q;
        mul_d     = mul_q;
        pm_d      = pm_q;
        prst_d    = prst_q;

        // Loads read the post-write arrays so a same-cycle write is what gets presented.
        if (!o_phi1_PCEN_n) begin
            fnum_d  = ch_d[ch_sel].fnum;
            block_d = ch_d[ch_sel].block;
            mul_d   = op_d[o_SLOT].mul;
            pm_d    = op_d[o_SLOT].pm;
            prst_d  = ~pend_d[prev_slot];
            if (!pend_set[prev_slot]) begin
                pend_d[prev_slot] = 1'b0;
            end
        end
    end

    always_ff @(posedge i_EMUCLK or posedge i_IC) begin
        if (i_IC) begin
            op_q    <= '{default: '0};
            ch_q    <= '{default: '0};
            rhy_q   <= 1'b0;
            pend_q  <= '0;
            fnum_q  <= '0;
            block_q <= '0;
            mul_q   <= '0;
            pm_q    <= 1'b0;
            prst_q  <= 1'b1;
        end else begin
            op_q    <= op_d;
            ch_q    <= ch_d;
            rhy_q   <= rhy_d;
            pend_q  <= pend_d;
            fnum_q  <= fnum_d;
            block_q <= block_d;
            mul_q   <= mul_d;
            pm_q    <= pm_d;
            prst_q  <= prst_d;
        end
    end

    assign o_RHYTHM_EN    = rhy_q;
    assign o_FNUM         = fnum_q;
    assign o_BLOCK        = block_q;
    assign o_MUL          = mul_q;
    assign o_PM           = pm_q;
    assign o_PG_PHASE_RST = prst_q;

endmodule

// File: tb/tb_ikaopll_pg_sequencer.sv
// Randomized self-checking bench for ikaopll_pg_sequencer against a frame-level reference model.
`timescale 1ns/1ps
module tb_ikaopll_pg_sequencer;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       phim_n = 1'b1;
    logic       wr = 1'b0;
    logic [5:0] addr = '0;
    logic [7:0] data = '0;

    logic       o_phi1_PCEN_n, o_phi1_NCEN_n;
    logic [4:0] o_SLOT;
    logic       o_CYCLE_17, o_CYCLE_20, o_CYCLE_21, o_RHYTHM_EN;
    logic [8:0] o_FNUM;
    logic [2:0] o_BLOCK;
    logic [3:0] o_MUL;
    logic       o_PM, o_PG_PHASE_RST;

    ikaopll_pg_sequencer #(.SLOTS(18), .PHI1_DIV(4)) dut (
        .i_EMUCLK       (clk),
        .i_IC           (rst),
        .i_phiM_PCEN_n  (phim_n),
        .i_WR           (wr),
        .i_ADDR         (addr),
        .i_DATA         (data),
        .o_phi1_PCEN_n  (o_phi1_PCEN_n),
        .o_phi1_NCEN_n  (o_phi1_NCEN_n),
        .o_SLOT         (o_SLOT),
        .o_CYCLE_17     (o_CYCLE_17),
        .o_CYCLE_20     (o_CYCLE_20),
        .o_CYCLE_21     (o_CYCLE_21),
        .o_RHYTHM_EN    (o_RHYTHM_EN),
        .o_FNUM         (o_FNUM),
        .o_BLOCK        (o_BLOCK),
        .o_MUL          (o_MUL),
        .o_PM           (o_PM),
        .o_PG_PHASE_RST (o_PG_PHASE_RST)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Reference model: counts phiM enables since reset and derives everything from that count.
    int unsigned m_en;
    logic [3:0]  m_mul  [18];
    logic        m_pm   [18];
    logic [8:0]  m_fnum [9];
    logic [2:0]  m_blk  [9];
    logic        m_key  [9];
    bit          m_pend [18];
    logic        m_rhy;
    logic [8:0]  e_fnum;
    logic [2:0]  e_blk;
    logic [3:0]  e_mul;
    logic        e_pm, e_rst;
    bit          exp_pcen, exp_ncen;
    logic        obs_pcen_n, obs_ncen_n;

    // NCEN falls on enables 2, 6, 10, ... so the slot is the count of those, mod 18.
    function automatic int unsigned m_slot();
        return ((m_en + 2) / 4) % 18;
    endfunction

    function automatic logic [26:0] dut_vec();
        return {o_SLOT, o_CYCLE_17, o_CYCLE_20, o_CYCLE_21, o_RHYTHM_EN,
                o_FNUM, o_BLOCK, o_MUL, o_PM, o_PG_PHASE_RST};
    endfunction

    function automatic logic [26:0] mdl_vec();
        int unsigned s;
        s = m_slot();
        return {5'(s), (s == 17), (s == 2), (s == 3), m_rhy,
                e_fnum, e_blk, e_mul, e_pm, e_rst};
    endfunction

    task automatic model_reset();
        m_en = 0; m_rhy = 1'b0;
        for (int i = 0; i < 18; i++) begin m_mul[i] = '0; m_pm[i] = 1'b0; m_pend[i] = 1'b0; end
        for (int i = 0; i < 9; i++) begin m_fnum[i] = '0; m_blk[i] = '0; m_key[i] = 1'b0; end
        e_fnum = '0; e_blk = '0; e_mul = '0; e_pm = 1'b0; e_rst = 1'b1;
    endtask

    // One i_EMUCLK: drive on negedge, sample the enables before the edge, update the model at the edge.
    task automatic tick(input bit en, input bit w, input logic [5:0] a, input logic [7:0] d);
        bit set_p [18];
        int unsigned s, prev, c;
        @(negedge clk);
        phim_n = ~en; wr = w; addr = a; data = d;
        #1;
        obs_pcen_n = o_phi1_PCEN_n;
        obs_ncen_n = o_phi1_NCEN_n;
        exp_pcen = en && ((m_en + 1) % 4 == 0);
        exp_ncen = en && ((m_en + 1) % 4 == 2);
        @(posedge clk);
        for (int i = 0; i < 18; i++) set_p[i] = 1'b0;
        if (w) begin
            if (a < 18) begin
                m_pm[a] = d[7]; m_mul[a] = d[3:0];
            end else if (a == 18) begin
                m_rhy = d[5];
            end else if (a >= 24 && a < 33) begin
                m_fnum[a - 24][7:0] = d;
            end else if (a >= 40 && a < 49) begin
                c = a - 40;
                if (d[4] && !m_key[c]) begin
                    set_p[2*c] = 1'b1; set_p[2*c+1] = 1'b1;
                    m_pend[2*c] = 1'b1; m_pend[2*c+1] = 1'b1;
                end
                m_key[c] = d[4]; m_blk[c] = d[3:1]; m_fnum[c][8] = d[0];
            end
        end
        if (exp_pcen) begin
            s = m_slot();
            prev = (s + 17) % 18;
            e_fnum = m_fnum[s / 2]; e_blk = m_blk[s / 2];
            e_mul = m_mul[s]; e_pm = m_pm[s];
            e_rst = !m_pend[prev];
            if (!set_p[prev]) m_pend[prev] = 1'b0;
        end
        if (en) m_en++;
        #1;
    endtask

    task automatic test_reset();
        @(negedge clk);
        rst = 1'b1; phim_n = 1'b1; wr = 1'b0;
        model_reset();
        #1;
        checks++;
        if (dut_vec() !== {5'd0, 3'b000, 1'b0, 9'd0, 3'd0, 4'd0, 1'b0, 1'b1}) begin
            errors++; $display("FAIL reset_outputs got %h expected %h", dut_vec(),
                               {5'd0, 3'b000, 1'b0, 9'd0, 3'd0, 4'd0, 1'b0, 1'b1});
        end
        checks++;
        if ({o_phi1_PCEN_n, o_phi1_NCEN_n} !== 2'b11) begin
            errors++; $display("FAIL reset_enables got %b%b expected 11", o_phi1_PCEN_n, o_phi1_NCEN_n);
        end
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_enables();
        int unsigned np = 0, nn = 0, k = 0;
        logic [3:0]  order = '0;
        logic [4:0]  s_after [2];
        s_after[0] = '1; s_after[1] = '1;
        for (int i = 0; i < 8; i++) begin
            tick(1, 0, 0, 0);
            checks++;
            if ({obs_pcen_n, obs_ncen_n} !== {~exp_pcen, ~exp_ncen}) begin
                errors++; $display("FAIL enable_pulse n=%0d got %b%b expected %b%b", i,
                                   obs_pcen_n, obs_ncen_n, ~exp_pcen, ~exp_ncen);
            end
            if (!obs_pcen_n) begin np++; if (k < 4) order[3-k] = 1'b1; k++; end
            if (!obs_ncen_n) begin if (nn < 2) s_after[nn] = o_SLOT; nn++; if (k < 4) order[3-k] = 1'b0; k++; end
            tick(0, 0, 0, 0);
        end
        checks++;
        if (np != 2 || nn != 2) begin
            errors++; $display("FAIL enable_count got pcen=%0d ncen=%0d expected 2 and 2", np, nn);
        end
        checks++;
        if (k != 4 || order !== 4'b0101) begin
            errors++; $display("FAIL enable_order got %b (k=%0d) expected 0101 (N,P,N,P)", order, k);
        end
        checks++;
        if (s_after[0] !== 5'd1 || s_after[1] !== 5'd2) begin
            errors++; $display("FAIL slot_steps got %0d,%0d expected 1,2", s_after[0], s_after[1]);
        end
    endtask

    task automatic test_wrap();
        bit wrapped = 1'b0;
        logic [4:0] last;
        last = o_SLOT;
        for (int i = 0; i < 72; i++) begin
            tick(1, 0, 0, 0);
            checks++;
            if (dut_vec() !== mdl_vec()) begin
                errors++; $display("FAIL wrap_vec i=%0d got %h expected %h", i, dut_vec(), mdl_vec());
            end
            if (last == 5'd17 && o_SLOT == 5'd0) wrapped = 1'b1;
            last = o_SLOT;
        end
        checks++;
        if (!wrapped) begin
            errors++; $display("FAIL slot_wrap got no 17->0 transition expected one");
        end
    endtask

    task automatic test_params();
        int unsigned h4 = 0, h5 = 0;
        tick(0, 1, 6'h1A, 8'h55);
        tick(0, 1, 6'h2A, 8'h07);
        tick(0, 1, 6'h05, 8'h8A);
        for (int i = 0; i < 144; i++) begin
            tick(1, 0, 0, 0);
            checks++;
            if (dut_vec() !== mdl_vec()) begin
                errors++; $display("FAIL params_vec i=%0d got %h expected %h", i, dut_vec(), mdl_vec());
            end
            if (exp_pcen && m_slot() == 4) begin
                h4++; checks++;
                if (o_FNUM !== 9'h155 || o_BLOCK !== 3'd3) begin
                    errors++; $display("FAIL slot4_params got fnum=%h block=%0d expected 155 3", o_FNUM, o_BLOCK);
                end
            end
            if (exp_pcen && m_slot() == 5) begin
                h5++; checks++;
                if (o_FNUM !== 9'h155 || o_BLOCK !== 3'd3 || o_MUL !== 4'hA || o_PM !== 1'b1) begin
                    errors++; $display("FAIL slot5_params got fnum=%h block=%0d mul=%h pm=%b expected 155 3 a 1",
                                       o_FNUM, o_BLOCK, o_MUL, o_PM);
                end
            end
        end
        checks++;
        if (h4 != 2 || h5 != 2) begin
            errors++; $display("FAIL params_loads got %0d,%0d expected 2,2", h4, h5);
        end
    endtask

    task automatic test_keyon();
        int unsigned lows = 0, l5 = 0, l6 = 0;
        tick(0, 1, 6'h2A, 8'h10);
        for (int i = 0; i < 216; i++) begin
            tick(1, 0, 0, 0);
            checks++;
            if (dut_vec() !== mdl_vec()) begin
                errors++; $display("FAIL keyon_vec i=%0d got %h expected %h", i, dut_vec(), mdl_vec());
            end
            if (exp_pcen && !o_PG_PHASE_RST) begin
                lows++; if (o_SLOT == 5'd5) l5++; if (o_SLOT == 5'd6) l6++;
            end
        end
        checks++;
        if (lows != 2 || l5 != 1 || l6 != 1) begin
            errors++; $display("FAIL keyon_reset got lows=%0d s5=%0d s6=%0d expected 2 1 1", lows, l5, l6);
        end
        lows = 0;
        tick(0, 1, 6'h2A, 8'h10);
        for (int i = 0; i < 144; i++) begin
            tick(1, 0, 0, 0);
            if (exp_pcen && !o_PG_PHASE_RST) lows++;
        end
        checks++;
        if (lows != 0) begin
            errors++; $display("FAIL keyon_rewrite got lows=%0d expected 0", lows);
        end
    endtask

    task automatic test_back_to_back();
        bit found = 1'b0;
        int unsigned lows = 0, l7 = 0, l8 = 0;
        tick(0, 1, 6'h2B, 8'h00);
        for (int i = 0; i < 400 && !found; i++) begin
            if (m_en % 4 == 3 && m_slot() == 7) found = 1'b1;
            else tick(1, 0, 0, 0);
        end
        checks++;
        if (!found) begin
            errors++; $display("FAIL collide_search got no slot-7 PCEN within budget expected one");
        end else begin
            tick(1, 1, 6'h2B, 8'h10);
            for (int i = 0; i < 144; i++) begin
                tick(1, 0, 0, 0);
                checks++;
                if (dut_vec() !== mdl_vec()) begin
                    errors++; $display("FAIL collide_vec i=%0d got %h expected %h", i, dut_vec(), mdl_vec());
                end
                if (exp_pcen && !o_PG_PHASE_RST) begin
                    lows++; if (o_SLOT == 5'd7) l7++; if (o_SLOT == 5'd8) l8++;
                end
            end
            checks++;
            if (lows != 2 || l7 != 1 || l8 != 1) begin
                errors++; $display("FAIL collide_reset got lows=%0d s7=%0d s8=%0d expected 2 1 1", lows, l7, l8);
            end
        end
    endtask

    task automatic test_random();
        bit en, w;
        for (int i = 0; i < 900; i++) begin
            en = ($urandom % 3) != 0;
            w  = ($urandom % 4) == 0;
            tick(en, w, 6'($urandom % 64), 8'($urandom));
            checks++;
            if ({obs_pcen_n, obs_ncen_n} !== {~exp_pcen, ~exp_ncen}) begin
                errors++; $display("FAIL random_enables i=%0d got %b%b expected %b%b", i,
                                   obs_pcen_n, obs_ncen_n, ~exp_pcen, ~exp_ncen);
            end
            checks++;
            if (dut_vec() !== mdl_vec()) begin
                errors++; $display("FAIL random_vec i=%0d got %h expected %h", i, dut_vec(), mdl_vec());
            end
        end
    endtask

    task automatic test_midreset();
        bit found = 1'b0;
        int unsigned lows = 0;
        for (int i = 0; i < 200 && !found; i++) begin
            if (m_slot() == 10) found = 1'b1;
            else tick(1, 0, 0, 0);
        end
        tick(0, 1, 6'h28, 8'h00);
        tick(0, 1, 6'h28, 8'h10);
        tick(0, 1, 6'h00, 8'hFF);
        tick(1, 0, 0, 0);
        @(posedge clk);
        #3;
        rst = 1'b1; phim_n = 1'b1; wr = 1'b0;
        model_reset();
        #1;
        checks++;
        if (dut_vec() !== {5'd0, 3'b000, 1'b0, 9'd0, 3'd0, 4'd0, 1'b0, 1'b1}) begin
            errors++; $display("FAIL midreset_outputs got %h expected %h", dut_vec(),
                               {5'd0, 3'b000, 1'b0, 9'd0, 3'd0, 4'd0, 1'b0, 1'b1});
        end
        repeat (3) @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 144; i++) begin
            tick(1, 0, 0, 0);
            checks++;
            if (dut_vec() !== mdl_vec()) begin
                errors++; $display("FAIL midreset_vec i=%0d got %h expected %h", i, dut_vec(), mdl_vec());
            end
            if (exp_pcen && !o_PG_PHASE_RST) lows++;
        end
        checks++;
        if (lows != 0) begin
            errors++; $display("FAIL midreset_pending got lows=%0d expected 0", lows);
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        model_reset();
        test_reset();
        test_enables();
        test_wrap();
        test_params();
        test_keyon();
        test_back_to_back();
        test_random();
        test_midreset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
